dram_scan_ctrl: RTL and testbench

- Initiator for the single-port distributed RAM (1024 x 32, synchronous write, asynchronous read on spo).
- On a start pulse it drives we/a/d to fill an address window with a deterministic pattern, then reads the window back and compares each word.
- Reports an error count and the first failing address.
- Used for board bring-up and memory self-test ahead of the CPU datapath.

---
 rtl/dram_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_dram_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dram_scan_ctrl.sv
// Memory self-test initiator for a synchronous-write / asynchronous-read RAM.
// It fills an address window with seed+i, then reads it back and records the error count and the first bad address.
module dram_scan_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_cnt,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err_addr,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_spo
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    mode_q;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] hold_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   i;
  logic          last;
  logic [DW-1:0] pattern;
  logic [AW-1:0] addr;
  logic          mismatch;

  // Offset i is AW+1 bits so that len = 2^AW can be counted, but only AW bits address the RAM.
  assign last     = (i == len_q - (AW+1)'(1));
  assign pattern  = seed_q + DW'(i);
  assign addr     = base_q + i[AW-1:0];
  assign mismatch = (mem_spo != pattern);

  assign mem_addr = addr;
  assign mem_data = (state == FILL) ? pattern : hold_q;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)        state_nx = DONE;
          else if (mode == 2'd1) state_nx = CHECK;
          else                  state_nx = FILL;
        end
      end
      FILL: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (last) state_nx = mode_q[1] ? CHECK : DONE;
      end
      CHECK: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q          <= '0;
      seed_q          <= '0;
      hold_q          <= '0;
      base_q          <= '0;
      len_q           <= '0;
      i               <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q          <= mode;
            seed_q          <= seed;
            base_q          <= base;
            len_q           <= len;
            i               <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
          end
        end
        FILL: begin
          hold_q <= pattern;
          i      <= last ? '0 : i + (AW+1)'(1);
        end
        CHECK: begin
          // RAM read is asynchronous, so the compare happens in the same cycle as the address.
          if (mismatch) begin
            err_cnt <= err_cnt + (AW+1)'(1);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_addr  <= addr;
            end
          end
          i <= i + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_scan_ctrl.sv
// Bench for dram_scan_ctrl: RAM model plus write/done scoreboards checked by a negedge monitor.
module tb_dram_scan_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] seed = '0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, first_err_valid, mem_we;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_err_addr, mem_addr;
  logic [DW-1:0] mem_data, mem_spo;

  dram_scan_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .seed(seed), .base(base), .len(len),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_spo(mem_spo)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_data;
  assign mem_spo = ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
  typedef struct { int c; int e; bit v; int fa; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (busy) busy_cnt++;
    if (mem_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(w.a));
        chk("wr_data", 64'(mem_data), 64'(w.d));
        chk("wr_cycle", 64'(cyc - t0), 64'(w.c));
        chk("busy_in_fill", 64'(busy), 1);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = dn_q.pop_front();
        chk("done_cycle", 64'(cyc - t0), 64'(d.c));
        chk("err_cnt", 64'(err_cnt), 64'(d.e));
        chk("first_err_valid", 64'(first_err_valid), 64'(d.v));
        chk("first_err_addr", 64'(first_err_addr), 64'(d.fa));
        chk("busy_at_done", 64'(busy), 0);
      end
    end
  end

  // Issue a start in cycle 0; push nwr expected writes and (if dcyc >= 0) one done.
  task automatic issue(input logic [1:0] m, input logic [DW-1:0] s, input logic [AW-1:0] b,
                       input logic [AW:0] l, input int nwr, input int dcyc,
                       input int e, input bit v, input int fa);
    dn_t d;
    @(negedge clk); #1;
    mode = m; seed = s; base = b; len = l; start = 1'b1;
    t0 = cyc;
    busy_cnt = 0;
    for (int k = 0; k < nwr; k++) begin
      wr_t w;
      w.a = b + AW'(k);
      w.d = s + DW'(k);
      w.c = k + 1;
      wr_q.push_back(w);
    end
    if (dcyc >= 0) begin
      d.c = dcyc; d.e = e; d.v = v; d.fa = fa;
      dn_q.push_back(d);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000 && (dn_q.size() != 0); k++) begin
      @(negedge clk); #2;
    end
    @(negedge clk); #2;
    chk("done_timeout", 64'(dn_q.size()), 0);
    chk("writes_left", 64'(wr_q.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_data", 64'(mem_data), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);
    chk("rst_fev", 64'(first_err_valid), 0);
    chk("rst_fea", 64'(first_err_addr), 0);
    rstn = 1'b1;

    // Fill only: 0x100..0x103 at 0..3, done in cycle 5
    issue(2'd0, 32'h0000_0100, 10'd0, 11'd4, 4, 5, 0, 0, 0);
    wait_done();
    chk("fill_busy_cycles", 64'(busy_cnt), 4);

    // Wrap with fill+check: 1022,1023,0,1; done in cycle 9
    issue(2'd2, 32'hFFFF_FFFE, 10'd1022, 11'd4, 4, 9, 0, 0, 0);
    wait_done();
    chk("wrap_busy_cycles", 64'(busy_cnt), 8);
    chk("wrap_ram0", 64'(ram[0]), 64'h0);
    chk("wrap_ram1023", 64'(ram[1023]), 64'hFFFF_FFFF);

    // Corruption: fill, clobber 19 and 21, check only
    issue(2'd0, 32'hA5A5_0000, 10'd16, 11'd8, 8, 9, 0, 0, 0);
    wait_done();
    ram[19] = '0;
    ram[21] = '0;
    issue(2'd1, 32'hA5A5_0000, 10'd16, 11'd8, 0, 9, 2, 1, 19);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_err_cnt", 64'(err_cnt), 2);
    chk("hold_fea", 64'(first_err_addr), 19);

    // len=0: done in cycle 1, no writes, results cleared
    issue(2'd2, 32'h0000_0005, 10'd7, 11'd0, 0, 1, 0, 0, 0);
    wait_done();
    chk("len0_busy_cycles", 64'(busy_cnt), 0);

    // Start while busy is ignored
    issue(2'd0, 32'h1234_0000, 10'd200, 11'd4, 4, 5, 0, 0, 0);
    @(posedge clk); #1;
    mode = 2'd2; seed = 32'h0; base = 10'd500; len = 11'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Reset in cycle 3 of an 8-word fill
    issue(2'd0, 32'hCAFE_0000, 10'd40, 11'd8, 3, -1, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_we", 64'(mem_we), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_done", 64'(done), 0);
    chk("rst_mid_writes", 64'(wr_q.size()), 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle_busy", 64'(busy), 0);
    issue(2'd0, 32'h0000_0077, 10'd1020, 11'd6, 6, 7, 0, 0, 0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
